// File: rtl/regs_wb_arbiter_pkg.sv
// regs_wb_arbiter_pkg: shared CPU definitions for the register write-back path.
//   REG_AW / REG_DW : default register address / data widths
//   REG_ZERO        : hard-wired zero register address (writes are discarded)
//   src_e           : write-back source encoding shared with the main control unit
package regs_wb_arbiter_pkg;
    localparam int REG_AW = 5;
    localparam int REG_DW = 32;
    localparam logic [REG_AW-1:0] REG_ZERO = '0;
    typedef enum logic {
        SRC_MEM = 1'b0,
        SRC_ALU = 1'b1
    } src_e;
endpackage

// File: rtl/regs_wb_arbiter_wb_hold.sv
// wb_hold_entry: one-entry write-back hold register.
//   clk, rst            : clock, synchronous active-high reset
//   req_valid/addr/data : incoming write-back request
//   grant               : entry is being written to the register file this cycle
//   rd_a, rd_b          : decode read addresses to compare against
//   ready               : request is accepted this cycle when req_valid is high
//   load                : request is being stored this cycle (non-zero address)
//   v, addr, data       : current entry contents
//   match_a, match_b    : entry holds an unwritten value for rd_a / rd_b
module wb_hold_entry
    import regs_wb_arbiter_pkg::*;
#(
    parameter int AW = REG_AW,
    parameter int DW = REG_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_data,
    input  logic          grant,
    input  logic [AW-1:0] rd_a,
    input  logic [AW-1:0] rd_b,
    output logic          ready,
    output logic          load,
    output logic          v,
    output logic [AW-1:0] addr,
    output logic [DW-1:0] data,
    output logic          match_a,
    output logic          match_b
);
    // Free when empty or draining this cycle; nothing is accepted during reset.
    assign ready = !rst & (!v | grant);
    // Zero-register requests are acknowledged but never buffered.
    assign load = req_valid & ready & (req_addr != AW'(REG_ZERO));
    assign match_a = v & (addr == rd_a);
    assign match_b = v & (addr == rd_b);

    always_ff @(posedge clk) begin
        if (rst) begin
            v    <= 1'b0;
            addr <= '0;
            data <= '0;
        end else if (load) begin
            v    <= 1'b1;
            addr <= req_addr;
            data <= req_data;
        end else if (grant) begin
            v    <= 1'b0;
        end
    end
endmodule

// File: rtl/regs_wb_arbiter.sv
// regs_wb_arbiter: arbitrates ALU and load write-backs onto the single register-file write port.
//   clk, rst                     : clock, synchronous active-high reset
//   alu_valid/addr/data, ready   : ALU write-back request handshake
//   mem_valid/addr/data, ready   : load write-back request handshake
//   L_S, Wt_addr, wt_data        : register-file write port (driven from hold entries)
//   R_addr_A, R_addr_B           : decode read addresses
//   hazard_A, hazard_B           : a buffered, unwritten value targets that read address
module regs_wb_arbiter
    import regs_wb_arbiter_pkg::*;
#(
    parameter int AW = REG_AW,
    parameter int DW = REG_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          alu_valid,
    input  logic [AW-1:0] alu_addr,
    input  logic [DW-1:0] alu_data,
    output logic          alu_ready,
    input  logic          mem_valid,
    input  logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_data,
    output logic          mem_ready,
    output logic          L_S,
    output logic [AW-1:0] Wt_addr,
    output logic [DW-1:0] wt_data,
    input  logic [AW-1:0] R_addr_A,
    input  logic [AW-1:0] R_addr_B,
    output logic          hazard_A,
    output logic          hazard_B
);
    logic          alu_v, mem_v, alu_load, mem_load;
    logic [AW-1:0] alu_a, mem_a;
    logic [DW-1:0] alu_d, mem_d;
    logic          alu_ma, alu_mb, mem_ma, mem_mb;
    logic          grant_alu, grant_mem, same, pick_alu, alu_keep, mem_keep;
    src_e          rr;
    logic          age;

    wb_hold_entry #(.AW(AW), .DW(DW)) u_alu (
        .clk(clk), .rst(rst),
        .req_valid(alu_valid), .req_addr(alu_addr), .req_data(alu_data),
        .grant(grant_alu), .rd_a(R_addr_A), .rd_b(R_addr_B),
        .ready(alu_ready), .load(alu_load),
        .v(alu_v), .addr(alu_a), .data(alu_d),
        .match_a(alu_ma), .match_b(alu_mb)
    );

    wb_hold_entry #(.AW(AW), .DW(DW)) u_mem (
        .clk(clk), .rst(rst),
        .req_valid(mem_valid), .req_addr(mem_addr), .req_data(mem_data),
        .grant(grant_mem), .rd_a(R_addr_A), .rd_b(R_addr_B),
        .ready(mem_ready), .load(mem_load),
        .v(mem_v), .addr(mem_a), .data(mem_d),
        .match_a(mem_ma), .match_b(mem_mb)
    );

    always_comb begin
        same      = (alu_a == mem_a);
        // Same destination must retire in program order; otherwise alternate.
        pick_alu  = same ? age : (rr == SRC_ALU);
        grant_alu = !rst & alu_v & (!mem_v | pick_alu);
        grant_mem = !rst & mem_v & (!alu_v | !pick_alu);
        alu_keep  = alu_v & !grant_alu;
        mem_keep  = mem_v & !grant_mem;
        L_S       = grant_alu | grant_mem;
        Wt_addr   = grant_alu ? alu_a : grant_mem ? mem_a : '0;
        wt_data   = grant_alu ? alu_d : grant_mem ? mem_d : '0;
        hazard_A  = (R_addr_A != AW'(REG_ZERO)) & (alu_ma | mem_ma);
        hazard_B  = (R_addr_B != AW'(REG_ZERO)) & (alu_mb | mem_mb);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr  <= SRC_MEM;
            age <= 1'b0;
        end else begin
            if (alu_v & mem_v & !same)
                rr <= grant_alu ? SRC_MEM : SRC_ALU;
            // age=1 means the ALU entry is older; a freshly loaded entry is always younger.
            if (alu_load & mem_load)
                age <= 1'b1;
            else if (alu_load & mem_keep)
                age <= 1'b0;
            else if (mem_load & alu_keep)
                age <= 1'b1;
        end
    end
endmodule

// File: tb/tb_regs_wb_arbiter.sv
// tb_regs_wb_arbiter: directed self-checking bench for regs_wb_arbiter.
module tb_regs_wb_arbiter;
    logic        clk, rst;
    logic        alu_valid, alu_ready, mem_valid, mem_ready;
    logic [4:0]  alu_addr, mem_addr, Wt_addr, R_addr_A, R_addr_B;
    logic [31:0] alu_data, mem_data, wt_data;
    logic        L_S, hazard_A, hazard_B;
    logic [31:0] rf [32];
    int          n_tests = 0;
    int          n_fail = 0;

    regs_wb_arbiter dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
        .L_S(L_S), .Wt_addr(Wt_addr), .wt_data(wt_data),
        .R_addr_A(R_addr_A), .R_addr_B(R_addr_B),
        .hazard_A(hazard_A), .hazard_B(hazard_B)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (L_S === 1'b1) rf[Wt_addr] <= wt_data;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
        mem_valid = 1'b0; mem_addr = '0; mem_data = '0;
    endtask

    logic [4:0] alu_seq [3];
    logic [4:0] mem_seq [3];
    logic [4:0] exp_order [6];
    logic [4:0] obs [$];

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = '0;
        alu_seq = '{5'd1, 5'd2, 5'd3};
        mem_seq = '{5'd9, 5'd10, 5'd11};
        exp_order = '{5'd9, 5'd1, 5'd10, 5'd2, 5'd11, 5'd3};
        idle();
        R_addr_A = '0; R_addr_B = '0;
        rst = 1'b1;
        #2;
        check("rst_alu_ready", alu_ready, 0);
        check("rst_mem_ready", mem_ready, 0);
        check("rst_ls", L_S, 0);
        step();
        rst = 1'b0;
        #1;
        check("post_rst_ls", L_S, 0);
        check("post_rst_waddr", Wt_addr, 0);
        check("post_rst_wdata", wt_data, 0);
        check("post_rst_alu_ready", alu_ready, 1);
        check("post_rst_mem_ready", mem_ready, 1);
        check("post_rst_hazA", hazard_A, 0);
        check("post_rst_hazB", hazard_B, 0);

        // single ALU write with hazard visibility
        alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'h1234_5678; R_addr_A = 5'd5;
        #1;
        check("alu5_hazA_pre_accept", hazard_A, 0);
        step();
        idle();
        #1;
        check("alu5_ls", L_S, 1);
        check("alu5_waddr", Wt_addr, 5);
        check("alu5_wdata", wt_data, 32'h1234_5678);
        check("alu5_hazA_buffered", hazard_A, 1);
        step();
        check("alu5_ls_after", L_S, 0);
        check("alu5_hazA_after", hazard_A, 0);
        check("alu5_rf", rf[5], 32'h1234_5678);

        // same-address ordering
        alu_valid = 1'b1; alu_addr = 5'd7; alu_data = 32'hA;
        mem_valid = 1'b1; mem_addr = 5'd7; mem_data = 32'hB;
        R_addr_B = 5'd7;
        #1;
        step();
        idle();
        #1;
        check("same_hazB", hazard_B, 1);
        check("same_ls1", L_S, 1);
        check("same_addr1", Wt_addr, 7);
        check("same_data1", wt_data, 32'hA);
        step();
        check("same_ls2", L_S, 1);
        check("same_addr2", Wt_addr, 7);
        check("same_data2", wt_data, 32'hB);
        step();
        check("same_ls3", L_S, 0);
        check("same_rf7", rf[7], 32'hB);
        R_addr_A = '0; R_addr_B = '0;

        // round-robin streaming
        begin
            int ai = 0;
            int mi = 0;
            for (int c = 0; c < 12; c++) begin
                logic ar, mr;
                alu_valid = (ai < 3); alu_addr = (ai < 3) ? alu_seq[ai] : 5'd0;
                alu_data = 32'hA00 + 32'(alu_addr);
                mem_valid = (mi < 3); mem_addr = (mi < 3) ? mem_seq[mi] : 5'd0;
                mem_data = 32'hB00 + 32'(mem_addr);
                #1;
                if (L_S) obs.push_back(Wt_addr);
                if (c >= 1 && c <= 4) begin
                    check($sformatf("rr_alu_ready_c%0d", c), alu_ready, (c % 2 == 0));
                    check($sformatf("rr_mem_ready_c%0d", c), mem_ready, (c % 2 == 1));
                end
                ar = alu_valid & alu_ready;
                mr = mem_valid & mem_ready;
                step();
                if (ar) ai++;
                if (mr) mi++;
            end
            idle();
            check("rr_write_count", obs.size(), 6);
            for (int i = 0; i < 6; i++)
                check($sformatf("rr_order_%0d", i), (i < obs.size()) ? obs[i] : 5'h1f, exp_order[i]);
            check("rr_rf10", rf[10], 32'hB0A);
            check("rr_rf3", rf[3], 32'hA03);
        end

        // zero address
        alu_valid = 1'b1; alu_addr = 5'd0; alu_data = 32'hFFFF_FFFF; R_addr_A = 5'd0;
        #1;
        check("zero_alu_ready", alu_ready, 1);
        step();
        idle();
        #1;
        check("zero_ls", L_S, 0);
        check("zero_hazA", hazard_A, 0);
        step();
        check("zero_ls2", L_S, 0);
        check("zero_rf0", rf[0], 0);

        // reset mid-operation
        alu_valid = 1'b1; alu_addr = 5'd12; alu_data = 32'hC;
        mem_valid = 1'b1; mem_addr = 5'd13; mem_data = 32'hD;
        #1;
        step();
        idle();
        rst = 1'b1;
        R_addr_A = 5'd12;
        #1;
        check("midrst_ls", L_S, 0);
        check("midrst_alu_ready", alu_ready, 0);
        step();
        rst = 1'b0;
        #1;
        check("midrst_after_ls", L_S, 0);
        check("midrst_after_alu_ready", alu_ready, 1);
        check("midrst_after_mem_ready", mem_ready, 1);
        check("midrst_after_hazA", hazard_A, 0);
        check("midrst_rf12", rf[12], 0);
        check("midrst_rf13", rf[13], 0);
        mem_valid = 1'b1; mem_addr = 5'd3; mem_data = 32'h33;
        #1;
        step();
        idle();
        #1;
        check("midrst_mem3_ls", L_S, 1);
        check("midrst_mem3_addr", Wt_addr, 3);
        check("midrst_mem3_data", wt_data, 32'h33);
        step();

        // back-to-back single source
        for (int c = 0; c < 4; c++) begin
            mem_valid = (c < 3); mem_addr = 5'(4 + c); mem_data = 32'h400 + 32'(c);
            #1;
            if (c < 3) check($sformatf("b2b_mem_ready_c%0d", c), mem_ready, 1);
            if (c > 0) begin
                check($sformatf("b2b_ls_c%0d", c), L_S, 1);
                check($sformatf("b2b_addr_c%0d", c), Wt_addr, 32'(3 + c));
                check($sformatf("b2b_data_c%0d", c), wt_data, 32'h400 + 32'(c - 1));
            end
            step();
        end
        idle();
        #1;
        check("b2b_ls_end", L_S, 0);
        check("b2b_rf6", rf[6], 32'h402);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
